// File: rtl/clk_div_ctrl_if.sv
// Divisor configuration handshake between the register interface and clk_div_ctrl.
interface clk_div_ctrl_if #(
  parameter int DIV_W = 8
);
  logic             cfg_valid;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_valid, output cfg_div, input cfg_ready, input cfg_err);
  modport slave  (input cfg_valid, input cfg_div, output cfg_ready, output cfg_err);
endinterface

// File: rtl/clk_div_ctrl.sv
// Glitch-free runtime-programmable clock divider: ratio changes only at period
// boundaries, start/stop sequenced so clk_div never produces a runt pulse.
module clk_div_ctrl #(
  parameter int DIV_W   = 8,
  parameter int DEF_DIV = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  clk_div_ctrl_if.slave    cfg,
  output logic             clk_div,
  output logic             tick,
  output logic             busy,
  output logic [DIV_W-1:0] cur_div
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] cur_div_q, cur_div_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic             pend_v_q, pend_v_d;
  logic             pos_q, pos_d;
  logic             neg_q;
  logic             tick_q, tick_d;
  logic             cfg_err_q, cfg_err_d;
  logic             wrap, accept, div_ok;

  // NOTE: every output of this block is given a default before any branch, so
  // no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_div_d  = cur_div_q;
    pend_v_d   = pend_v_q;
    pend_div_d = pend_div_q;
    tick_d     = 1'b0;
    wrap       = (cnt_q == cur_div_q - 1'b1);
    accept     = cfg.cfg_valid && !pend_v_q;
    div_ok     = (cfg.cfg_div >= DIV_W'(2));
    cfg_err_d  = accept && !div_ok;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept && div_ok) cur_div_d = cfg.cfg_div;
        if (en) begin
          state_d = S_RUN;
          tick_d  = 1'b1;
        end
      end
      default: begin
        if (wrap) begin
          cnt_d = '0;
          if (pend_v_q) begin
            cur_div_d = pend_div_q;
            pend_v_d  = 1'b0;
          end
          // A stop request only takes effect at the wrap, never mid-period.
          if (en) begin
            state_d = S_RUN;
            tick_d  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = en ? S_RUN : S_DRAIN;
        end
        if (accept && div_ok) begin
          pend_v_d   = 1'b1;
          pend_div_d = cfg.cfg_div;
        end
      end
    endcase

    pos_d = (state_d != S_IDLE) && (cnt_d < (cur_div_d >> 1));
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cur_div_q  <= DIV_W'(DEF_DIV);
      pend_v_q   <= 1'b0;
      pend_div_q <= '0;
      pos_q      <= 1'b0;
      tick_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_div_q  <= cur_div_d;
      pend_v_q   <= pend_v_d;
      pend_div_q <= pend_div_d;
      pos_q      <= pos_d;
      tick_q     <= tick_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  // Half-cycle extension of the high phase for odd ratios.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) neg_q <= 1'b0;
    else        neg_q <= pos_q;
  end

  assign clk_div       = pos_q | (cur_div_q[0] & neg_q);
  assign tick          = tick_q;
  assign busy          = (state_q != S_IDLE);
  assign cur_div       = cur_div_q;
  assign cfg.cfg_ready = !pend_v_q;
  assign cfg.cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Scoreboard bench for clk_div_ctrl: a period-level reference model predicts ticks,
// divisors and error pulses; a monitor checks the waveform shape of each period.
module tb_clk_div_ctrl;
  localparam int DIV_W   = 8;
  localparam int DEF_DIV = 5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             clk_div, tick, busy;
  logic [DIV_W-1:0] cur_div;

  clk_div_ctrl_if #(.DIV_W(DIV_W)) cfg_if ();

  clk_div_ctrl #(.DIV_W(DIV_W), .DEF_DIV(DEF_DIV)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .cfg     (cfg_if.slave),
    .clk_div (clk_div),
    .tick    (tick),
    .busy    (busy),
    .cur_div (cur_div)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: period-level view (active, position in period, divisors)
  bit m_active, m_pend_v;
  int m_phase, m_cur, m_pend_div;
  int exp_tick_q[$];
  int exp_err_q[$];
  bit mon_flush;

  // Monitor bookkeeping for the period being observed
  bit mon_open;
  int mon_half, mon_div, mon_shape_bad;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_active = 1'b0;
    m_phase  = 0;
    m_cur    = DEF_DIV;
    m_pend_v = 1'b0;
    m_pend_div = 0;
    exp_tick_q.delete();
    exp_err_q.delete();
    mon_flush = 1'b1;
  endfunction

  // Effect of one posedge given the inputs presented to it.
  function automatic void model_step();
    bit acc;
    int d;
    acc = cfg_if.cfg_valid && !m_pend_v;
    d   = int'(cfg_if.cfg_div);
    if (acc && d < 2) exp_err_q.push_back(d);
    if (!m_active) begin
      if (acc && d >= 2) m_cur = d;
      if (en) begin
        m_active = 1'b1;
        m_phase  = 0;
        exp_tick_q.push_back(m_cur);
      end
    end else begin
      if (m_phase == m_cur - 1) begin
        m_phase = 0;
        if (m_pend_v) begin
          m_cur    = m_pend_div;
          m_pend_v = 1'b0;
        end
        if (en) exp_tick_q.push_back(m_cur);
        else    m_active = 1'b0;
      end else begin
        m_phase++;
      end
      if (acc && d >= 2) begin
        m_pend_v   = 1'b1;
        m_pend_div = d;
      end
    end
  endfunction

  // Entered and left at posedge+1; presents inputs for exactly one edge.
  task automatic step(input bit e, input bit v, input int d);
    en               = e;
    cfg_if.cfg_valid = v;
    cfg_if.cfg_div   = DIV_W'(d);
    @(posedge clk);
    if (rst_n) model_step();
    #1;
  endtask

  task automatic close_period();
    check("period_half_cycles", mon_half, 2 * mon_div);
    check("period_shape_errors", mon_shape_bad, 0);
    mon_open = 1'b0;
  endtask

  task automatic mon_sample_half();
    if (mon_open) begin
      if (clk_div !== (mon_half < mon_div)) mon_shape_bad++;
      mon_half++;
    end
  endtask

  task automatic mon_posedge();
    int div_now;
    if (mon_flush) begin
      mon_open  = 1'b0;
      mon_flush = 1'b0;
    end
    check("cur_div", cur_div, m_cur);
    check("busy", busy, m_active);
    check("cfg_ready", cfg_if.cfg_ready, !m_pend_v);
    check("cfg_err", cfg_if.cfg_err, exp_err_q.size() > 0);
    if (exp_err_q.size() > 0) void'(exp_err_q.pop_front());
    check("tick", tick, exp_tick_q.size() > 0);
    if (exp_tick_q.size() > 0) begin
      div_now = exp_tick_q.pop_front();
      if (mon_open) close_period();
      mon_open      = 1'b1;
      mon_div       = div_now;
      mon_half      = 0;
      mon_shape_bad = 0;
    end else if (mon_open && !busy) begin
      close_period();
    end
    if (!mon_open) check("clk_div_idle", clk_div, 0);
    mon_sample_half();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #3 mon_posedge();
      @(negedge clk);
      #3 mon_sample_half();
    end
  end

  initial begin
    bit en_r;
    bit v;
    int d;
    cfg_if.cfg_valid = 1'b0;
    cfg_if.cfg_div   = '0;
    model_reset();
    mon_open = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_clk_div", clk_div, 0);
    check("rst_tick", tick, 0);
    check("rst_busy", busy, 0);
    check("rst_cfg_err", cfg_if.cfg_err, 0);
    check("rst_cfg_ready", cfg_if.cfg_ready, 1);
    check("rst_cur_div", cur_div, DEF_DIV);
    rst_n = 1'b1;

    // Default ratio 5
    repeat (12) step(1, 0, 0);

    // Ratio 4 written mid-period; ready stays low until the boundary
    for (int i = 0; i < 20 && m_phase != 2; i++) step(1, 0, 0);
    step(1, 1, 4);
    check("ready_low_after_write", cfg_if.cfg_ready, 0);
    repeat (14) step(1, 0, 0);

    // Illegal divisors
    step(1, 1, 1);
    step(1, 0, 0);
    step(1, 1, 0);
    repeat (8) step(1, 0, 0);

    // Stop at cnt=1 with N=7
    step(1, 1, 7);
    for (int i = 0; i < 40 && !(m_cur == 7 && m_phase == 1); i++) step(1, 0, 0);
    check("reached_n7_cnt1", (m_cur == 7 && m_phase == 1), 1);
    repeat (12) step(0, 0, 0);
    check("stopped_busy", busy, 0);
    check("stopped_clk_div", clk_div, 0);

    // Divisor 3 accepted on the same edge as the start
    step(1, 1, 3);
    check("start_cur_div3", cur_div, 3);
    check("start_tick", tick, 1);
    repeat (9) step(1, 0, 0);

    // Reset during the high phase with a divisor pending
    step(1, 1, 8);
    for (int i = 0; i < 40 && !(m_cur == 8 && m_phase == 0); i++) step(1, 0, 0);
    step(1, 1, 6);
    check("pending_before_rst", cfg_if.cfg_ready, 0);
    #1;
    check("clk_div_before_rst", clk_div, 1);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid_clk_div", clk_div, 0);
    check("rst_mid_cfg_ready", cfg_if.cfg_ready, 1);
    check("rst_mid_cur_div", cur_div, DEF_DIV);
    check("rst_mid_busy", busy, 0);
    en = 1'b0;
    cfg_if.cfg_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("ready_after_release", cfg_if.cfg_ready, 1);

    // Randomized traffic
    en_r = 1'b1;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0) en_r = !en_r;
      v = ($urandom_range(0, 5) == 0);
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : int'($urandom_range(2, 40));
      step(en_r, v, d);
    end

    repeat (60) step(0, 0, 0);
    check("final_busy", busy, 0);
    check("final_tick_queue_empty", exp_tick_q.size(), 0);
    check("final_err_queue_empty", exp_err_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Runtime-programmable clock-divider controller. It generates a divided clock of ratio N (2 to 2^DIV_W−1) on `clk_div`, with 50 % duty for even N and (N/2)/N high via a negedge-extended half cycle for odd N. It accepts new ratios over a valid/ready handshake and applies them only at period boundaries, so the output never glitches. Start and stop are sequenced so that `clk_div` never produces a runt pulse. It sits between the register interface and the divided-clock consumers.

## Interface
- `DIV_W`, 8, divisor width.
- `DEF_DIV`, 5, divisor loaded by reset; must be 2 to 2^DIV_W−1.
- `clk`  in  1  source clock; counter on posedge, odd-extension flop on negedge.
- `rst_n`  in  1  reset. **One clock; reset is asynchronous and active-low.**
- `en`  in  1  run request; level-sensitive.
- `cfg_valid`  in  1  new divisor offered.
- `cfg_div`  in  DIV_W  requested divisor.
- `cfg_ready`  out  1  controller can accept a divisor.
- `cfg_err`  out  1  one-cycle pulse: an accepted divisor was rejected.
- `clk_div`  out  1  divided clock.
- `tick`  out  1  one-cycle pulse at each period start.
- `busy`  out  1  high in RUN or DRAIN.
- `cur_div`  out  DIV_W  divisor in effect.

## Operation
- **States:**
  - IDLE: `clk_div` is 0 and the counter is held at 0.
  - RUN: the counter runs.
  - DRAIN: the current period is finished, then the block goes to IDLE.
- **Transitions:**
  - IDLE → RUN when `en`=1 at a posedge.
  - RUN → DRAIN when `en`=0 at a posedge, unless `cnt`=`cur_div`−1, in which case RUN → IDLE directly.
  - DRAIN → IDLE at the edge where `cnt` wraps.
  - DRAIN → RUN if `en` returns to 1 before the wrap. The period continues with no restart.
- **Counter:** `cnt` runs 0..`cur_div`−1 and wraps to 0. The boundary is the edge where `cnt`=`cur_div`−1 advances to 0.
- **Output generation:**
  - `pos_q` (posedge flop) = (`cnt_next` < `cur_div`>>1).
  - `neg_q` (negedge flop) samples `pos_q`.
  - `clk_div` = `pos_q` | (`cur_div`[0] & `neg_q`).
- **Handshake:**
  - `cfg_ready` = !`pend_v`.
  - A transfer occurs when `cfg_valid` & `cfg_ready` at a posedge.
  - `cfg_div` < 2 is rejected: `cfg_err` pulses the next cycle and nothing changes.
- **Applying a divisor:**
  - In IDLE, an accepted divisor loads `cur_div` at the acceptance edge.
  - In RUN or DRAIN, it is stored in `pend_v`/`pend_div` and loaded into `cur_div` at the next boundary. `pend_v` then clears, so `cfg_ready` returns to 1 on the cycle after the boundary.
- **Simultaneous events:**
  - Acceptance and `en` rise at the same edge in IDLE: the start uses the new divisor.
  - Acceptance on the boundary edge itself: the value goes pending and applies at the following boundary.
  - Rejected divisor while a value is pending: the pending value is unaffected.
- **Reset:**
  - Asserted at any time, it clears immediately: state IDLE, `cnt`=0, `pos_q`=`neg_q`=0, `clk_div`=0, `tick`=0, `busy`=0, `cfg_err`=0, `pend_v`=0, `cfg_ready`=1, `cur_div`=`DEF_DIV`.
  - Mid-period truncation caused by reset is permitted.

## Timing
- **Start:** at edge E0 where `en`=1 in IDLE, `cnt`←0, `pos_q`←1, `tick`←1 and `busy`←1. `clk_div` rises at E0 with zero cycles of latency after sampling.
- **Period:**
  - `clk_div` period is exactly `cur_div` clk cycles.
  - High time is `cur_div`>>1 cycles for even divisors and (`cur_div`>>1)+0.5 cycles for odd divisors.
  - `tick` is high for the single cycle following each boundary edge and E0.
- **Ratio change:** the old ratio completes its full period. The first edge of the new period is the boundary edge, so there is no glitch. `cur_div[0]` changes only at the boundary, when `pos_q` and `neg_q` are already 0 (N≥2).
- **Stop:** after `en` falls, `clk_div` completes the current period. `busy` drops at the wrap edge, `clk_div` stays 0 from there, and `tick` is not asserted at the final wrap.
- **N=2:** 1 cycle high and 1 cycle low.
- **N=3:** 1.5 cycles high and 1.5 cycles low.

## Test plan
- Reset, `en`=1 with the default of 5 → `clk_div` period 5 cycles, high 2.5 cycles; `tick` every 5 cycles; `cur_div`=5.
- In RUN, write 4 mid-period → `cfg_ready`=0 until the boundary; the current 5-cycle period completes; then period is 4 with 2 cycles high; no glitch on `clk_div`.
- Write `cfg_div`=1, then 0 → a `cfg_err` pulse for each; `cur_div` is unchanged; `clk_div` continues uninterrupted.
- Drop `en` at `cnt`=1 with N=7 → 5 more cycles to the wrap, then IDLE; `clk_div`=0 and `busy`=0 after the wrap; no runt pulse.
- In IDLE, write 3 with `en` rising at the same edge → the first period is already 3 cycles (1.5 high); `tick` at E0.
- Assert `rst_n`=0 mid-high-phase with a value pending → `clk_div` goes to 0 immediately; `pend_v` clears; `cur_div`=5; `cfg_ready`=1 after release.
